// File: rtl/cpu_types_pkg.sv
// cpu_types: shared fetch-stage payload and FSM state types
package cpu_types;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instruction;
  } fetch_entry_t;
  typedef enum logic [1:0] {FETCH_IDLE, FETCH_WAIT, FETCH_DROP} fetch_state_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: power-of-two prefetch FIFO of {pc, instruction} entries with flush
module fetch_fifo
  import cpu_types::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wdata,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  always_comb begin
    wr_d  = flush ? '0 : wr_q + AW'(push);
    rd_d  = flush ? '0 : rd_q + AW'(pop);
    cnt_d = flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    head  = mem_q[rd_q];
    count = cnt_q;
    empty = cnt_q == '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_q] <= wdata;
  end
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch PC, single-outstanding imem reads, prefetch FIFO, redirect flush
// FETCH_STATS_EN adds stat_fetched / stat_flushed counters.
module instruction_fetch
  import cpu_types::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_flushed
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  fetch_state_t state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d;
  logic [CW-1:0] count;
  logic empty, push, pop, accept;
  fetch_entry_t head;
  always_comb begin
    imem_req    = !rst && state_q == FETCH_IDLE && !redirect && count < CW'(FIFO_DEPTH);
    imem_addr   = fetch_pc_q;
    accept      = imem_req && imem_ready;
    push        = state_q == FETCH_WAIT && imem_rvalid && !redirect;
    pop         = instr_valid && instr_ready && !redirect;
    fetch_pc_d  = redirect ? {redirect_pc[31:2], 2'b00} : accept ? fetch_pc_q + 32'd4 : fetch_pc_q;
    req_pc_d    = accept ? fetch_pc_q : req_pc_q;
    // a response arriving alongside a redirect still retires the outstanding read
    state_d     = accept ? FETCH_WAIT :
                  (state_q != FETCH_IDLE && imem_rvalid) ? FETCH_IDLE :
                  (redirect && state_q == FETCH_WAIT) ? FETCH_DROP : state_q;
    instr_valid = !empty;
    instruction = head.instruction;
    instr_pc    = head.pc;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata ('{pc: req_pc_q, instruction: imem_rdata}),
    .head  (head),
    .count (count),
    .empty (empty)
  );
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched_q, stat_fetched_d, stat_flushed_q, stat_flushed_d;
  always_comb begin
    stat_fetched_d = stat_fetched_q + 32'(push);
    // the outstanding read is counted once, when it becomes stale
    stat_flushed_d = redirect ? stat_flushed_q + 32'(count) + 32'(state_q == FETCH_WAIT) : stat_flushed_q;
    stat_fetched   = stat_fetched_q;
    stat_flushed   = stat_flushed_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_fetched_q <= '0;
      stat_flushed_q <= '0;
    end else begin
      stat_fetched_q <= stat_fetched_d;
      stat_flushed_q <= stat_flushed_d;
    end
  end
`endif
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed stimulus with an expected-PC scoreboard and pop monitor
module tb_instruction_fetch;
  logic clk, rst, imem_req, imem_ready, imem_rvalid, redirect, instr_valid, instr_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, instruction, instr_pc;
  logic [31:0] stat_fetched, stat_flushed;
  int vectors, miscompares, pops, mem_lat, left;
  logic pend;
  logic [31:0] paddr;
  logic [31:0] exp_q[$];

  instruction_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instruction(instruction), .instr_pc(instr_pc)
`ifdef FETCH_STATS_EN
    , .stat_fetched(stat_fetched), .stat_flushed(stat_flushed)
`endif
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] f(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_from(input logic [31:0] base);
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  // memory model: one outstanding read, response mem_lat cycles after accept
  initial begin
    imem_rvalid = 0;
    imem_rdata = 0;
    pend = 0;
    left = 0;
    paddr = 0;
    forever begin
      @(negedge clk);
      imem_rvalid = 0;
      if (pend) begin
        left--;
        if (left == 0) begin
          imem_rvalid = 1;
          imem_rdata = f(paddr);
          pend = 0;
        end
      end
      if (imem_req && imem_ready) begin
        pend = 1;
        left = mem_lat;
        paddr = imem_addr;
      end
    end
  end

  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!rst && instr_valid && instr_ready && !redirect) begin
        if (exp_q.size() == 0) chk("unexpected_pop", instr_pc, 32'hFFFF_FFFF);
        else begin
          e = exp_q.pop_front();
          chk("instr_pc", instr_pc, e);
          chk("instruction", instruction, f(e));
        end
        pops++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] h, a, fl, ft;
    int p0;
    vectors = 0; miscompares = 0; pops = 0; mem_lat = 1;
    rst = 1; imem_ready = 1; instr_ready = 1; redirect = 0; redirect_pc = 0;
    expect_from(32'h0);
    cyc(3);
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_valid", 32'(instr_valid), 0);
    rst = 0;
    #1;
    chk("first_req", 32'(imem_req), 1);
    chk("first_addr", imem_addr, 32'h0);
`ifdef FETCH_STATS_EN
    chk("rst_fetched", stat_fetched, 0);
    chk("rst_flushed", stat_flushed, 0);
`endif
    // 1: streaming 0x0, 0x4, 0x8
    for (int i = 0; i < 60 && pops < 3; i++) cyc(1);
    chk("t1_pops", 32'(pops >= 3), 1);
    // 2: backpressure fills the FIFO and stops issue
    instr_ready = 0;
    cyc(12);
    chk("t2_valid", 32'(instr_valid), 1);
    h = instr_pc;
    for (int i = 0; i < 4; i++) begin
      chk("t2_req_off", 32'(imem_req), 0);
      chk("t2_pc_hold", instr_pc, h);
      chk("t2_instr_hold", instruction, f(h));
      cyc(1);
    end
    p0 = pops;
    instr_ready = 1;
    for (int i = 0; i < 60 && pops < p0 + 4; i++) cyc(1);
    chk("t2_resume", 32'(pops >= p0 + 4), 1);
    // 3: redirect while a read is outstanding
    mem_lat = 3;
    cyc(12);
    for (int i = 0; i < 60 && !(pend && left == mem_lat); i++) cyc(1);
    chk("t3_in_wait", 32'(pend && left == mem_lat), 1);
    fl = stat_flushed;
    redirect = 1; redirect_pc = 32'h1003;
    expect_from(32'h1000);
    #1;
    chk("t3_req_redirect", 32'(imem_req), 0);
    cyc(1);
    redirect = 0;
    #1;
    chk("t3_valid_flushed", 32'(instr_valid), 0);
    chk("t3_req_drop", 32'(imem_req), 0);
    for (int i = 0; i < 20 && !imem_req; i++) cyc(1);
    chk("t3_refetch_addr", imem_addr, 32'h1000);
`ifdef FETCH_STATS_EN
    chk("t3_flushed", stat_flushed - fl, 1);
`endif
    p0 = pops;
    for (int i = 0; i < 60 && pops < p0 + 2; i++) cyc(1);
    chk("t3_pops", 32'(pops >= p0 + 2), 1);
    // 4: redirect coinciding with rvalid and a pop
    mem_lat = 2;
    instr_ready = 0;
    for (int i = 0; i < 60 && !instr_valid; i++) cyc(1);
    for (int i = 0; i < 60 && !(pend && left == 1); i++) cyc(1);
    chk("t4_setup", 32'(instr_valid && pend && left == 1), 1);
    fl = stat_flushed; ft = stat_fetched;
    redirect = 1; redirect_pc = 32'h2000; instr_ready = 1;
    expect_from(32'h2000);
    cyc(1);
    redirect = 0;
    #1;
    chk("t4_valid_off", 32'(instr_valid), 0);
    chk("t4_req", 32'(imem_req), 1);
    chk("t4_addr", imem_addr, 32'h2000);
`ifdef FETCH_STATS_EN
    chk("t4_no_push", stat_fetched - ft, 0);
    chk("t4_flushed", stat_flushed - fl, 2);
`endif
    p0 = pops;
    for (int i = 0; i < 60 && pops < p0 + 2; i++) cyc(1);
    chk("t4_pops", 32'(pops >= p0 + 2), 1);
    // 5: memory not ready holds the request
    mem_lat = 1;
    for (int i = 0; i < 20 && !imem_req; i++) cyc(1);
    imem_ready = 0;
    a = imem_addr;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t5_req_hold", 32'(imem_req), 1);
      chk("t5_addr_hold", imem_addr, a);
      cyc(1);
    end
    imem_ready = 1;
    p0 = pops;
    for (int i = 0; i < 60 && pops < p0 + 3; i++) cyc(1);
    chk("t5_pops", 32'(pops >= p0 + 3), 1);
    // 6: reset while waiting; the late response must be ignored
    mem_lat = 2;
    cyc(6);
    for (int i = 0; i < 60 && !(pend && left == 2); i++) cyc(1);
    chk("t6_in_wait", 32'(pend && left == 2), 1);
    rst = 1;
    expect_from(32'h0);
    cyc(1);
    rst = 0;
    #1;
    chk("t6_req", 32'(imem_req), 1);
    chk("t6_addr", imem_addr, 32'h0);
    chk("t6_valid", 32'(instr_valid), 0);
`ifdef FETCH_STATS_EN
    chk("t6_fetched", stat_fetched, 0);
    chk("t6_flushed", stat_flushed, 0);
`endif
    p0 = pops;
    for (int i = 0; i < 60 && pops < p0 + 2; i++) cyc(1);
    chk("t6_pops", 32'(pops >= p0 + 2), 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
